led_blink_sched: RTL

//   Shares the board's single status LED between NUM_REQ requesters.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_rr_arbiter.sv | 37 +++
 rtl/led_blink_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared state encoding, blink-count width and ms-to-cycle helper for the LED scheduler.
package led_pkg;

    localparam int BLINK_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP,
        ST_DONE
    } led_state_t;

    function automatic int ms_to_cycles(input int freq, input int ms);
        return freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational requester arbiter: round-robin from ptr, or lowest-index-wins when
// LED_SCHED_FIXED_PRIO_EN is defined (ptr is then ignored).
module led_rr_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int unsigned j;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef LED_SCHED_FIXED_PRIO_EN
            j = k;
`else
            j = (k + 32'(ptr)) % 32'(NUM_REQ);
`endif
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/led_blink_sched.sv
// Shares one status LED between NUM_REQ requesters: arbitrate, blink N times, dark gap, done.
// Optional LED_SCHED_FIXED_PRIO_EN (in led_rr_arbiter) selects fixed priority over round-robin.
module led_blink_sched
    import led_pkg::*;
#(
    parameter int clock_freq = 100_000_000,
    parameter int NUM_REQ    = 4,
    parameter int BLINK_MS   = 250,
    parameter int GAP_MS     = 1000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [BLINK_CNT_W*NUM_REQ-1:0]   blinks,
    output logic                             ack,
    output logic                             done,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             busy,
    output logic                             led
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int ON_CYC  = ms_to_cycles(clock_freq, BLINK_MS);
    localparam int GAP_CYC = ms_to_cycles(clock_freq, GAP_MS);
    localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    led_state_t               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BLINK_CNT_W-1:0]   blk_q, blk_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         gid_q, gid_d;
    logic                     ack_q, ack_d;

    logic [NUM_REQ-1:0]       arb_grant;
    logic [IDX_W-1:0]         arb_idx;
    logic [BLINK_CNT_W-1:0]   blk_sel;

    led_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign blk_sel = blinks[int'(arb_idx)*BLINK_CNT_W +: BLINK_CNT_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|arb_grant) begin
                    ack_d   = 1'b1;
                    gid_d   = arb_idx;
                    ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    blk_d   = blk_sel;
                    cnt_d   = '0;
                    state_d = (blk_sel == '0) ? ST_DONE : ST_ON;
                end
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OFF: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d   = '0;
                    blk_d   = blk_q - 1'b1;
                    state_d = (blk_q == BLINK_CNT_W'(1)) ? ST_GAP : ST_ON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A zero-count grant lands here straight from IDLE; the ack cycle is spent
            // in DONE with done masked, so done still follows ack by one cycle.
            ST_DONE: begin
                if (!ack_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack      = ack_q;
    assign done     = (state_q == ST_DONE) && !ack_q;
    assign busy     = (state_q != ST_IDLE);
    assign led      = (state_q == ST_ON);
    assign grant_id = gid_q;

endmodule
